avmm_sha3_slave: RTL and testbench

Avalon-MM slave front-end for the SHA3 core: the responder at the far end of the 8-bit-address / 32-bit-data Avalon-MM bus driven by the bench master. It decodes register accesses, buffers message words in a small first-word-fall-through FIFO streamed to the hash core, captures the digest, and exposes control and status. Every access is paced by `avs_s0_wait_request`.

---
 rtl/avmm_sha3_slave.sv | 161 ++++++++++++++++
 tb/tb_avmm_sha3_slave.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avmm_sha3_slave.sv
// Avalon-MM slave front-end for the SHA3 core.
// Decodes CTRL/STATUS/DATA/DIGEST registers, buffers message words in a
// first-word-fall-through FIFO feeding the core, and captures the digest.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | wait_request=1; sample read/write, accept when not stalled
//   ST_ACK   | wait_request=0; transfer completes, back to IDLE next edge
module avmm_sha3_slave #(
  parameter int          FIFO_DEPTH    = 8,
  parameter int          DIGEST_WORDS  = 16,
  parameter logic [31:0] UNMAPPED_DATA = 32'hDEADBEEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [7:0]                avs_s0_address,
  input  logic                      avs_s0_read,
  input  logic                      avs_s0_write,
  input  logic [31:0]               avs_s0_write_data,
  output logic [31:0]               avs_s0_read_data,
  output logic                      avs_s0_wait_request,
  output logic [31:0]               msg_data,
  output logic                      msg_last,
  output logic                      msg_valid,
  input  logic                      msg_ready,
  output logic                      core_start,
  input  logic [32*DIGEST_WORDS-1:0] digest_in,
  input  logic                      digest_valid
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACK  = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          start_q, start_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [32:0]   mem_q [FIFO_DEPTH];
  logic [32:0]   mem_d [FIFO_DEPTH];
  logic [31:0]   digest_q [DIGEST_WORDS];
  logic [31:0]   digest_d [DIGEST_WORDS];

  logic        full, empty, data_wr, accept, push, pop, ctrl_wr, do_start, do_clr;
  logic [31:0] status_word, rd_val;

  // Access decode: a DATA write stalls in IDLE while the FIFO is full.
  always_comb begin
    full     = (level_q == LW'(FIFO_DEPTH));
    empty    = (level_q == '0);
    data_wr  = avs_s0_write && (avs_s0_address == 8'h02 || avs_s0_address == 8'h03);
    accept   = (state_q == ST_IDLE) && (avs_s0_read || avs_s0_write) && !(data_wr && full);
    push     = accept && data_wr;
    ctrl_wr  = accept && avs_s0_write && (avs_s0_address == 8'h00);
    do_start = ctrl_wr && avs_s0_write_data[0];
    do_clr   = ctrl_wr && avs_s0_write_data[1];
    pop      = !empty && msg_ready;
    status_word = {16'h0, 8'(level_q), 4'h0, empty, full, done_q, busy_q};
  end

  // Read mux; a simultaneous read+write is a write and returns zero.
  always_comb begin
    rd_val = UNMAPPED_DATA;
    for (int i = 0; i < DIGEST_WORDS; i++) begin
      if (avs_s0_address == 8'(32'h10 + i)) rd_val = digest_q[i];
    end
    case (avs_s0_address)
      8'h00, 8'h02, 8'h03: rd_val = 32'h0;
      8'h01:               rd_val = status_word;
      default: ;
    endcase
    if (avs_s0_write) rd_val = 32'h0;
  end

  // Bus FSM, read-data capture and start pulse.
  always_comb begin
    state_d = ST_IDLE;
    rdata_d = rdata_q;
    start_d = do_start;
    if (state_q == ST_IDLE && accept) begin
      state_d = ST_ACK;
      rdata_d = rd_val;
    end
  end

  // Control/status flags; START wins over a same-edge digest for BUSY/DONE.
  always_comb begin
    busy_d   = busy_q;
    done_d   = done_q;
    digest_d = digest_q;
    if (digest_valid) begin
      busy_d = 1'b0;
      done_d = 1'b1;
      for (int i = 0; i < DIGEST_WORDS; i++) digest_d[i] = digest_in[32*i +: 32];
    end
    if (do_clr) done_d = 1'b0;
    if (do_start) begin
      busy_d = 1'b1;
      done_d = 1'b0;
    end
  end

  // FIFO pointers and storage; a flush overrides any same-edge pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    mem_d    = mem_q;
    if (push) mem_d[wr_ptr_q] = {(avs_s0_address == 8'h03), avs_s0_write_data};
    if (do_clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      level_d = level_q + LW'(push) - LW'(pop);
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      rdata_q  <= 32'h0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++)   mem_q[i]    <= '0;
      for (int i = 0; i < DIGEST_WORDS; i++) digest_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      rdata_q  <= rdata_d;
      start_q  <= start_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      mem_q    <= mem_d;
      digest_q <= digest_d;
    end
  end

  assign avs_s0_wait_request = (state_q == ST_IDLE);
  assign avs_s0_read_data    = rdata_q;
  assign core_start          = start_q;
  assign msg_valid           = !empty;
  assign msg_data            = empty ? 32'h0 : mem_q[rd_ptr_q][31:0];
  assign msg_last            = empty ? 1'b0  : mem_q[rd_ptr_q][32];

endmodule

// File: tb/tb_avmm_sha3_slave.sv
// Scoreboarded bench for avmm_sha3_slave: a queue-based model predicts bus
// read data, core_start and the message stream; monitors compare on ACK
// cycles and on stream handshakes.
module tb_avmm_sha3_slave;

  localparam int DEPTH = 8;
  localparam int DW    = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [7:0]      avs_s0_address = '0;
  logic            avs_s0_read = 1'b0;
  logic            avs_s0_write = 1'b0;
  logic [31:0]     avs_s0_write_data = '0;
  logic [31:0]     avs_s0_read_data;
  logic            avs_s0_wait_request;
  logic [31:0]     msg_data;
  logic            msg_last;
  logic            msg_valid;
  logic            msg_ready = 1'b0;
  logic            core_start;
  logic [32*DW-1:0] digest_in = '0;
  logic            digest_valid = 1'b0;

  avmm_sha3_slave #(.FIFO_DEPTH(DEPTH), .DIGEST_WORDS(DW), .UNMAPPED_DATA(32'hDEADBEEF)) dut (
    .clk(clk), .rst(rst),
    .avs_s0_address(avs_s0_address), .avs_s0_read(avs_s0_read), .avs_s0_write(avs_s0_write),
    .avs_s0_write_data(avs_s0_write_data), .avs_s0_read_data(avs_s0_read_data),
    .avs_s0_wait_request(avs_s0_wait_request),
    .msg_data(msg_data), .msg_last(msg_last), .msg_valid(msg_valid), .msg_ready(msg_ready),
    .core_start(core_start), .digest_in(digest_in), .digest_valid(digest_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic chk; logic [31:0] rd; logic start; } exp_t;
  exp_t        exp_q[$];
  logic [32:0] exp_msg[$];

  int vectors = 0;
  int miscompares = 0;

  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic [31:0] m_dig [DW];

  initial for (int i = 0; i < DW; i++) m_dig[i] = 32'h0;

  function automatic logic [31:0] model_read(input logic [7:0] a);
    int n;
    n = exp_msg.size();
    if (a == 8'h01) return {16'h0, 8'(n), 4'h0, (n == 0), (n == DEPTH), m_done, m_busy};
    if (a == 8'h00 || a == 8'h02 || a == 8'h03) return 32'h0;
    if (a >= 8'h10 && int'(a) < 16 + DW) return m_dig[int'(a) - 16];
    return 32'hDEADBEEF;
  endfunction

  // Bus monitor: every ACK cycle consumes one scoreboard entry.
  always @(negedge clk) begin
    if (rst === 1'b1 && avs_s0_wait_request === 1'b0) begin
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_ack actual=ack required=no_ack");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.chk) begin
          vectors++;
          if (avs_s0_read_data !== e.rd) begin
            miscompares++;
            $display("FAIL read_data actual=%08h required=%08h", avs_s0_read_data, e.rd);
          end
        end
        vectors++;
        if (core_start !== e.start) begin
          miscompares++;
          $display("FAIL core_start_ack actual=%b required=%b", core_start, e.start);
        end
      end
    end else if (rst === 1'b1 && core_start !== 1'b0) begin
      miscompares++;
      $display("FAIL core_start_idle actual=%b required=0", core_start);
    end
  end

  // Stream monitor: every handshake consumes one expected message word.
  always @(negedge clk) begin
    if (rst === 1'b1 && msg_valid === 1'b1 && msg_ready === 1'b1) begin
      if (exp_msg.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_msg actual=%b_%08h required=none", msg_last, msg_data);
      end else begin
        logic [32:0] w;
        w = exp_msg.pop_front();
        vectors++;
        if ({msg_last, msg_data} !== w) begin
          miscompares++;
          $display("FAIL msg_word actual=%b_%08h required=%b_%08h", msg_last, msg_data, w[32], w[31:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s actual=%08h required=%08h", name, act, req);
    end
  endtask

  // Issues one access starting from IDLE; expects acceptance on the first edge.
  task automatic access(input logic rd, input logic wr, input logic [7:0] a,
                        input logic [31:0] d, input logic with_dig);
    int   n;
    logic got;
    n = 0;
    got = 1'b0;
    check("wait_request_before", {31'h0, avs_s0_wait_request}, 32'h1);
    avs_s0_address = a;
    avs_s0_write_data = d;
    avs_s0_read = rd;
    avs_s0_write = wr;
    if (with_dig) digest_valid = 1'b1;
    while (!got && n < 50) begin
      @(posedge clk); #1;
      n++;
      digest_valid = 1'b0;
      if (avs_s0_wait_request === 1'b0) got = 1'b1;
    end
    avs_s0_read = 1'b0;
    avs_s0_write = 1'b0;
    if (!got) begin
      vectors++;
      miscompares++;
      $display("FAIL access_timeout addr=%02h actual=no_ack required=ack", a);
    end else begin
      check("access_latency", n, 1);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_read(input logic [7:0] a);
    exp_q.push_back('{1'b1, model_read(a), 1'b0});
    access(1'b1, 1'b0, a, 32'h0, 1'b0);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d);
    exp_q.push_back('{1'b0, 32'h0, (a == 8'h00) && d[0]});
    if (a == 8'h02 || a == 8'h03) exp_msg.push_back({(a == 8'h03), d});
    if (a == 8'h00) begin
      if (d[1]) begin exp_msg.delete(); m_done = 1'b0; end
      if (d[0]) begin m_busy = 1'b1; m_done = 1'b0; end
    end
    access(1'b0, 1'b1, a, d, 1'b0);
  endtask

  task automatic load_digest(input logic [31:0] w0);
    for (int i = 0; i < DW; i++) begin
      m_dig[i] = (i == 0) ? w0 : $urandom;
      digest_in[32*i +: 32] = m_dig[i];
    end
  endtask

  task automatic pulse_digest(input logic [31:0] w0);
    load_digest(w0);
    m_busy = 1'b0;
    m_done = 1'b1;
    digest_valid = 1'b1;
    @(posedge clk); #1;
    digest_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    msg_ready = 1'b1;
    while (exp_msg.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    msg_ready = 1'b0;
    check("drain_left", exp_msg.size(), 0);
    check("drain_msg_valid", {31'h0, msg_valid}, 32'h0);
  endtask

  initial begin
    logic [31:0] d;
    int          op, n;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_wait_request", {31'h0, avs_s0_wait_request}, 32'h1);
    check("rst_read_data", avs_s0_read_data, 32'h0);
    check("rst_core_start", {31'h0, core_start}, 32'h0);
    check("rst_msg_valid", {31'h0, msg_valid}, 32'h0);
    check("rst_msg_data", msg_data, 32'h0);
    check("rst_msg_last", {31'h0, msg_last}, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;

    check("status_after_reset_model", model_read(8'h01), 32'h8);
    do_read(8'h01);

    // In-order streaming with the core ready.
    msg_ready = 1'b1;
    do_write(8'h02, 32'h11111111);
    do_write(8'h02, 32'h22222222);
    do_write(8'h03, 32'h33333333);
    drain();
    do_read(8'h01);

    // Fill the FIFO, then stall a ninth write until one pop frees space.
    for (int i = 0; i < DEPTH; i++) do_write(8'h02, $urandom);
    do_read(8'h01);
    d = $urandom;
    exp_q.push_back('{1'b0, 32'h0, 1'b0});
    avs_s0_address = 8'h02;
    avs_s0_write_data = d;
    avs_s0_write = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("stall_wait_request", {31'h0, avs_s0_wait_request}, 32'h1);
    end
    msg_ready = 1'b1;
    @(posedge clk); #1;
    msg_ready = 1'b0;
    check("stall_pop_edge_wait", {31'h0, avs_s0_wait_request}, 32'h1);
    @(posedge clk); #1;
    check("stall_release_wait", {31'h0, avs_s0_wait_request}, 32'h0);
    avs_s0_write = 1'b0;
    exp_msg.push_back({1'b0, d});
    @(posedge clk); #1;
    do_read(8'h01);
    drain();

    // START, digest, DONE.
    do_write(8'h00, 32'h1);
    do_read(8'h01);
    pulse_digest(32'hA5A5A5A5);
    do_read(8'h01);
    do_read(8'h10);
    do_read(8'h1F);

    // Unmapped accesses, and read+write treated as a write.
    do_read(8'h7F);
    do_write(8'h7F, $urandom);
    do_read(8'h01);
    exp_q.push_back('{1'b1, 32'h0, 1'b0});
    access(1'b1, 1'b1, 8'h7F, $urandom, 1'b0);

    // START on the same edge as digest_valid.
    load_digest($urandom);
    m_busy = 1'b1;
    m_done = 1'b0;
    exp_q.push_back('{1'b0, 32'h0, 1'b1});
    access(1'b0, 1'b1, 8'h00, 32'h1, 1'b1);
    do_read(8'h01);
    do_read(8'h13);

    // SOFT_CLR with words queued.
    pulse_digest($urandom);
    for (int i = 0; i < 5; i++) do_write(8'h02, $urandom);
    do_read(8'h01);
    do_write(8'h00, 32'h2);
    do_read(8'h01);
    check("soft_clr_msg_valid", {31'h0, msg_valid}, 32'h0);

    // Randomised traffic.
    for (int k = 0; k < 120; k++) begin
      op = $urandom_range(0, 7);
      case (op)
        0, 1: begin
          if (exp_msg.size() < DEPTH) do_write((op == 0) ? 8'h02 : 8'h03, $urandom);
          else do_read(8'h01);
        end
        2: do_read(8'h01);
        3: do_read(8'(16 + $urandom_range(0, DW - 1)));
        4: begin
          if ($urandom_range(0, 1) == 0) do_read(8'($urandom_range(4, 15)));
          else do_read(8'($urandom_range(32, 255)));
        end
        5: pulse_digest($urandom);
        6: do_write(8'h00, {$urandom_range(0, 255), 22'h0, 2'($urandom_range(0, 3))});
        default: drain();
      endcase
    end
    drain();
    do_read(8'h01);

    // Reset in the middle of an access with words queued.
    for (int i = 0; i < 3; i++) do_write(8'h02, $urandom);
    avs_s0_address = 8'h7F;
    avs_s0_read = 1'b1;
    @(posedge clk); #1;
    check("pre_reset_ack", {31'h0, avs_s0_wait_request}, 32'h0);
    check("pre_reset_data", avs_s0_read_data, 32'hDEADBEEF);
    #2 rst = 1'b0;
    #1;
    avs_s0_read = 1'b0;
    check("midrst_wait_request", {31'h0, avs_s0_wait_request}, 32'h1);
    check("midrst_read_data", avs_s0_read_data, 32'h0);
    check("midrst_msg_valid", {31'h0, msg_valid}, 32'h0);
    exp_msg.delete();
    m_busy = 1'b0;
    m_done = 1'b0;
    for (int i = 0; i < DW; i++) m_dig[i] = 32'h0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    do_read(8'h01);
    do_read(8'h10);

    n = 0;
    while (exp_q.size() != 0 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check("scoreboard_left", exp_q.size(), 0);
    check("stream_left", exp_msg.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
